// File: rtl/bin2bcd_serial_converter_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
package bin2bcd_serial_converter_pkg;

    localparam int unsigned BCD_DIGIT_WIDTH = 4;
    localparam logic [BCD_DIGIT_WIDTH-1:0] ADD3_THRESHOLD = 4'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bin2bcd_serial_converter_bcd_add3_digit.sv
// One BCD digit correction stage: add 3 when the digit would exceed 9 after doubling.
module bcd_add3_digit
    import bin2bcd_serial_converter_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] din,
    output logic [BCD_DIGIT_WIDTH-1:0] dout
);

    assign dout = (din > ADD3_THRESHOLD) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_serial_converter.sv
// Sequential binary-to-BCD converter, one input bit per clock, with start/ready/valid
// handshake and overflow detection when the value does not fit in DIGITS decimal digits.
module bin2bcd_serial_converter
    import bin2bcd_serial_converter_pkg::*;
#(
    parameter int unsigned INPUT_BIT_WIDTH = 16,
    parameter int unsigned DIGITS          = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [INPUT_BIT_WIDTH-1:0]        input_bin,
    output logic                              ready,
    output logic                              valid,
    output logic [BCD_DIGIT_WIDTH*DIGITS-1:0] digits,
    output logic                              overflow
);

    localparam int unsigned CntWidth = $clog2(INPUT_BIT_WIDTH + 1);
    localparam int unsigned BcdWidth = BCD_DIGIT_WIDTH * DIGITS;
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(INPUT_BIT_WIDTH);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    state_e                     state_q, state_d;
    logic [INPUT_BIT_WIDTH-1:0] shift_q, shift_d;
    logic [BcdWidth-1:0]        scratch_q, scratch_d, scratch_adj;
    logic [CntWidth-1:0]        cnt_q, cnt_d;
    logic                       sticky_q, sticky_d;
    logic [BcdWidth-1:0]        digits_q, digits_d;
    logic                       overflow_q, overflow_d;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
        bcd_add3_digit u_add3 (
            .din  (scratch_q[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
            .dout (scratch_adj[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH])
        );
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    shift_d   = input_bin;
                    scratch_d = '0;
                    cnt_d     = CntLoad;
                    sticky_d  = 1'b0;
                    state_d   = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                {scratch_d, shift_d} = {scratch_adj[BcdWidth-2:0], shift_q, 1'b0};
                // A set bit leaving the top digit means the value no longer fits.
                sticky_d = sticky_q | scratch_adj[BcdWidth-1];
                cnt_d    = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    // Outputs load on entry to DONE so they are visible alongside valid.
                    state_d    = StDone;
                    digits_d   = scratch_d;
                    overflow_d = sticky_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready    = (state_q != StShift);
    assign valid    = (state_q == StDone);
    assign digits   = digits_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_serial_converter.sv
// Self-checking bench: directed vectors, timing sequences and randomized/swept values
// checked by a divide/modulo reference model on three parameterizations.
module tb_bin2bcd_serial_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] input_bin = '0;

    logic        r5, v5, o5;
    logic [19:0] d5;
    logic        r4, v4, o4;
    logic [15:0] d4;
    logic        r14, v14, o14;
    logic [15:0] d14;

    int n_cmp = 0;
    int n_fail = 0;
    int unsigned q[3][$];

    always #5 clk = ~clk;

    bin2bcd_serial_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(5)) u_w16d5 (
        .clk(clk), .rst(rst), .start(start), .input_bin(input_bin),
        .ready(r5), .valid(v5), .digits(d5), .overflow(o5)
    );

    bin2bcd_serial_converter #(.INPUT_BIT_WIDTH(16), .DIGITS(4)) u_w16d4 (
        .clk(clk), .rst(rst), .start(start), .input_bin(input_bin),
        .ready(r4), .valid(v4), .digits(d4), .overflow(o4)
    );

    bin2bcd_serial_converter #(.INPUT_BIT_WIDTH(14), .DIGITS(4)) u_w14d4 (
        .clk(clk), .rst(rst), .start(start), .input_bin(input_bin[13:0]),
        .ready(r14), .valid(v14), .digits(d14), .overflow(o14)
    );

    function automatic int unsigned pow10(input int nd);
        int unsigned p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] ref_bcd(input int unsigned v, input int nd);
        logic [19:0] r = '0;
        int unsigned x = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_check(input int idx, input logic [19:0] gd, input logic go, input int nd);
        int unsigned v;
        if (q[idx].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb%0d_unexpected_valid: got valid expected none", idx);
            return;
        end
        v = q[idx].pop_front();
        check($sformatf("sb%0d_digits(%0d)", idx, v), 32'(gd), 32'(ref_bcd(v, nd)));
        check($sformatf("sb%0d_overflow(%0d)", idx, v), 32'(go), 32'(v >= pow10(nd)));
    endtask

    // Record accepted requests just before the sampling edge, when inputs are settled.
    always @(negedge clk) begin
        #4;
        if (!rst && start) begin
            if (r5)  q[0].push_back(32'(input_bin));
            if (r4)  q[1].push_back(32'(input_bin));
            if (r14) q[2].push_back(32'(input_bin[13:0]));
        end
    end

    always @(posedge rst) begin
        for (int i = 0; i < 3; i++) q[i].delete();
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (v5)  sb_check(0, d5, o5, 5);
            if (v4)  sb_check(1, {4'h0, d4}, o4, 4);
            if (v14) sb_check(2, {4'h0, d14}, o14, 4);
        end
    end

    task automatic wait_all_ready();
        int g = 0;
        while (!(r5 && r4 && r14) && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (g >= 60) check("ready_timeout", 32'(r5 & r4 & r14), 32'd1);
    endtask

    task automatic convert(input logic [15:0] v);
        wait_all_ready();
        input_bin = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_v5(output int n);
        n = 0;
        while (!v5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(v5), 32'd1);
    endtask

    typedef struct {
        logic [15:0] val;
        logic [19:0] d5;
        logic        o5;
        logic [15:0] d4;
        logic        o4;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;
        logic [19:0] cap;

        tbl[0] = '{16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{16'd1,     20'h00001, 1'b0, 16'h0001, 1'b0};
        tbl[2] = '{16'd599,   20'h00599, 1'b0, 16'h0599, 1'b0};
        tbl[3] = '{16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0};
        tbl[4] = '{16'd10000, 20'h10000, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'd12345, 20'h12345, 1'b0, 16'h2345, 1'b1};
        tbl[6] = '{16'd65535, 20'h65535, 1'b0, 16'h5535, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_ready",    32'(r5), 32'd1);
        check("rst_valid",    32'(v5), 32'd0);
        check("rst_digits",   32'(d5), 32'd0);
        check("rst_overflow", 32'(o5), 32'd0);
        check("rst_ready14",  32'(r14), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Latency/ready window for 599 on the 16-bit, 5-digit instance.
        convert(16'd599);
        nv = 0;
        for (int c = 1; c <= 16; c++) begin
            if (r5 || v5) nv++;
            @(negedge clk);
        end
        check("busy_window_ready_low", 32'(nv), 32'd0);
        check("t17_valid",    32'(v5), 32'd1);
        check("t17_ready",    32'(r5), 32'd1);
        check("t17_digits",   32'(d5), 32'h00599);
        check("t17_overflow", 32'(o5), 32'd0);
        check("t17_valid_d4", 32'(v4), 32'd1);
        @(negedge clk);
        check("valid_single_pulse", 32'(v5), 32'd0);
        check("digits_hold",        32'(d5), 32'h00599);

        // Back-to-back with start held high.
        wait_all_ready();
        input_bin = 16'd0;
        start = 1'b1;
        @(negedge clk);
        input_bin = 16'hFFFF;
        wait_v5(n);
        check("b2b_first_latency", 32'(n), 32'd16);
        check("b2b_first_digits",  32'(d5), 32'h00000);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!v5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap",        32'(n), 32'd17);
        check("b2b_second_d5",  32'(d5), 32'h65535);
        check("b2b_second_o5",  32'(o5), 32'd0);
        check("b2b_second_d4",  32'(d4), 32'h5535);
        check("b2b_second_o4",  32'(o4), 32'd1);

        // Directed table.
        foreach (tbl[i]) begin
            convert(tbl[i].val);
            wait_v5(n);
            check($sformatf("tbl%0d_d5", i), 32'(d5), 32'(tbl[i].d5));
            check($sformatf("tbl%0d_o5", i), 32'(o5), 32'(tbl[i].o5));
            check($sformatf("tbl%0d_v4", i), 32'(v4), 32'd1);
            check($sformatf("tbl%0d_d4", i), 32'(d4), 32'(tbl[i].d4));
            check($sformatf("tbl%0d_o4", i), 32'(o4), 32'(tbl[i].o4));
            repeat (3) @(negedge clk);
            check($sformatf("tbl%0d_hold", i), 32'(d5), 32'(tbl[i].d5));
        end

        // Start pulses and input changes while busy are ignored.
        convert(16'd1234);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            input_bin = 16'($urandom);
            start = (c % 2 == 0);
        end
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        cap = '0;
        for (int c = 0; c < 30; c++) begin
            if (v5) begin
                nv++;
                cap = d5;
            end
            @(negedge clk);
        end
        check("busy_start_one_valid", 32'(nv), 32'd1);
        check("busy_start_digits",    32'(cap), 32'h01234);

        // Reset in the middle of a conversion.
        convert(16'd142);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready",    32'(r5), 32'd1);
        check("midrst_valid",    32'(v5), 32'd0);
        check("midrst_digits",   32'(d5), 32'd0);
        check("midrst_overflow", 32'(o5), 32'd0);
        check("midrst_digits4",  32'(d4), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (v5 || v4 || v14) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);
        convert(16'd89);
        wait_v5(n);
        check("after_rst_digits", 32'(d5), 32'h00089);

        // Randomized values on all instances, checked by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            convert(16'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Strided sweep of the 14-bit, 4-digit range plus its edges.
        for (int i = 0; i <= 9999; i += 5) convert(16'(i));
        convert(16'd9999);
        convert(16'd10000);
        convert(16'd16383);

        repeat (40) @(negedge clk);
        check("sb0_drained", 32'(q[0].size()), 32'd0);
        check("sb1_drained", 32'(q[1].size()), 32'd0);
        check("sb2_drained", 32'(q[2].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_serial_converter.md
# bin2bcd_serial_converter

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It generalises the fixed 4-digit combinational converter to any input width and digit count. A start/ready/valid handshake replaces purely combinational output, and overflow detection is added. It sits between counters/arithmetic blocks and the multi-digit 7-segment display drivers, trading latency for area on wide inputs.

## Interface
- INPUT_BIT_WIDTH, 16: width of binary input; must be ≥ 1.
- DIGITS, 5: number of BCD output digits; must be ≥ 1.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request conversion of Input; sampled only when Ready=1.
- Input  in  INPUT_BIT_WIDTH  unsigned binary value, captured on the accepted Start edge.
- Ready  out  1  high in IDLE; converter accepts Start.
- Valid  out  1  single-cycle pulse; Digits/Overflow updated this cycle.
- Digits  out  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0], digit k in [4k+3:4k].
- Overflow  out  1  Input ≥ 10^DIGITS for the last completed conversion.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: Ready=1. Start=1 at an edge loads Input into the shift register, clears the BCD scratch register and the sticky overflow flag, loads the bit counter with INPUT_BIT_WIDTH, and moves to SHIFT.
- SHIFT, once per cycle:
  - Every scratch digit > 4 gets +3.
  - The {scratch, shift} register shifts left one bit.
  - The bit shifted out of the top digit ORs into the sticky overflow flag.
  - The counter decrements. When it reaches 0 after this shift, go to DONE.
- DONE: copy scratch to Digits and sticky flag to Overflow. Valid=1 for this one cycle, Ready=1, return to IDLE.
- Start=1 during DONE is accepted, giving back-to-back conversions.
- Start while busy (SHIFT) is ignored. It is not queued. Input changes while busy are ignored.
- Overflow case: Digits = Input mod 10^DIGITS and Overflow=1. Otherwise Overflow=0.
- Digits/Overflow hold their last values until the next DONE.
- Reset (any time, including mid-SHIFT):
  - State → IDLE, Ready=1, Valid=0, Digits=0, Overflow=0.
  - Scratch, shift register and counter are cleared.
  - An in-flight conversion is discarded, with no Valid.

## Timing
- Start accepted at edge T → Valid high in cycle T+INPUT_BIT_WIDTH+1. Latency is INPUT_BIT_WIDTH+1 cycles.
- Ready low from T+1 through T+INPUT_BIT_WIDTH. It goes high again with Valid.
- Throughput: one conversion per INPUT_BIT_WIDTH+1 cycles when Start is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Counter width is clog2(INPUT_BIT_WIDTH+1).

## Structure
- Shared package/header holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - BCD_DIGIT_WIDTH=4 and the add-3 threshold constant (4).
- Sub-module bcd_add3_digit: combinational, 4-bit in → 4-bit out (in>4 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- The top module holds the FSM, counter, shift/scratch registers and output registers.

## Test plan
- Convert 599 (W=16, D=5): Start at cycle 0 → Valid exactly at cycle 17, Digits=5'h00599 packed (0,0,5,9,9), Overflow=0, Ready low for cycles 1–16.
- Convert 0, then 65535 back-to-back with Start held high: first Valid gives all-zero digits, second Valid 17 cycles later gives 6,5,5,3,5.
- Overflow (W=16, D=4): Input=12345 → Digits 2,3,4,5, Overflow=1. Next conversion of 9999 → Overflow=0.
- Start pulses and Input changes during SHIFT: result reflects only the originally captured value, with exactly one Valid.
- Reset asserted at cycle 8 of a conversion of 142: outputs immediately 0 and Ready=1, no Valid. A new Start with 89 yields 0,0,0,8,9.
- Sweep 0–9999 (W=14, D=4), comparing each Valid result against a /10 and %10 reference model.
